tx_gearbox_66b64b: RTL and testbench
====================================

Name: tx_gearbox_66b64b

Overview:
Transmit-side counterpart of the receive block-sync/aligner path. It packs 66-bit coded blocks (2-bit sync header plus 64-bit payload) into a continuous 64-bit word stream. Every 32 accepted blocks produce 33 output words, so the block back-pressures its source for 1 cycle in 33. The block also contains a sync-header error injector used to exercise receiver unlock, downstream of the encoder/scrambler and ahead of the PMA interface.

Parameters:
NB_DATA_CODED, 66, input block width (sync header at bits [65:64]).
NB_DATA_OUT, 64, output word width.
NB_SEQ, 6, width of the gearbox sequence counter (values 0..32).
MAX_INVALID_SH, 6, maximum injectable consecutive bad headers.
NB_INVALID_CNT, $clog2(MAX_INVALID_SH)+1, width of the injection count.

Ports:
i_clock  in  1  single clock.
i_reset  in  1  synchronous reset, active-low.
i_enable  in  1  global enable; when low, all state holds and o_valid=0.
i_valid  in  1  i_data carries a block.
i_data  in  66  coded block; bits [65:64] are transmitted first.
o_ready  out  1  block is accepted this cycle when i_valid && o_ready && i_enable.
i_rf_inject_start  in  1  level input; a rising edge arms injection.
i_rf_inject_count  in  NB_INVALID_CNT  number of consecutive blocks to corrupt.
o_inject_busy  out  1  injection in progress.
o_data  out  64  packed word; bit 63 is transmitted first.
o_valid  out  1  o_data is valid.

Behaviour:
- Serial order: the stream is block bit 65 down to 0, then the next block, packed MSB-first into words.
- State:
  - seq counts 0..32. Residual fill F = 2*seq bits, held left-justified-low in a 64-bit residual register res.
- o_ready = i_reset && i_enable && (seq != 32). It is combinational from registers only and never depends on i_valid.
- Accept cycle (seq<32, handshake true):
  - cat = {res[F-1:0], blk}, width F+66.
  - o_data <= the top 64 bits of cat.
  - res low bits <= the bottom F+2 bits of cat.
  - seq <= seq+1.
  - o_valid <= 1.
- Flush cycle (seq==32 and i_enable):
  - o_data <= res[63:0]; o_valid <= 1; seq <= 0.
  - No input is accepted. The flush does not wait for i_valid.
- Idle cycle (seq<32 with no handshake, or i_enable=0):
  - o_valid <= 0. o_data, res and seq hold.
- Latency: 1 cycle from accept to o_data. Output is registered.
- Gaps in i_valid produce gaps in o_valid; no filler is generated.
- Injection:
  - An i_rf_inject_start rising edge (registered edge detect) with o_inject_busy=0 and i_rf_inject_count>0 loads inj_cnt <= i_rf_inject_count.
  - While inj_cnt>0, each accepted block has blk[65:64] forced to 2'b11 (payload untouched), and inj_cnt decrements.
  - o_inject_busy = (inj_cnt != 0).
  - A rising edge while busy is ignored. A count of 0 does nothing. Flush cycles do not decrement inj_cnt.
- Otherwise blk = i_data.
- Reset (i_reset=0, synchronous):
  - seq=0, res=0, o_data=0, o_valid=0, inj_cnt=0, edge register=0.
  - o_ready=0 while reset is asserted.
- Reset mid-frame discards the residual bits. The first post-reset word starts at block bit 65.
- Reset wins over every simultaneous event.

Decomposition:
- Shared package pcs_tx_pkg: NB_DATA_CODED, NB_DATA_OUT, SH_DATA=2'b01, SH_CTRL=2'b10, SH_INVALID=2'b11, GEARBOX_RATIO=32.
- One natural sub-module: sh_error_injector. It contains the edge detect, inj_cnt, and the header mux in front of the packer.

Test Plan:
- Reset release with blocks B0..B31 streamed back-to-back (each i_valid=1):
  - o_ready stays 1 for 32 cycles, then 0 for exactly 1 cycle.
  - 33 consecutive o_valid=1 words are produced.
  - The concatenated words equal the concatenated blocks bit-for-bit.
- Single block B0=66'h1_0123456789ABCDEF (header 01):
  - Word0 = B0[65:2] = 64'h4048D159E26AF37B.
  - Word1 begins with B0[1:0]=2'b11 followed by B1[65:4].
- Random i_valid gaps of 1-5 cycles, including a gap at seq==32:
  - The flush still occurs the cycle after the 32nd accept.
  - The word stream is identical to the gapless case; o_valid=0 during gaps.
- Reset asserted at seq=17:
  - o_valid=0 and o_ready=0 during reset.
  - After release, the next word equals the top 64 bits of the first new block and seq restarts at 0.
- Injection start edge with count=6 on data blocks:
  - Exactly the next 6 accepted blocks carry header 2'b11 and the 7th carries 2'b01.
  - o_inject_busy is high for those 6 accepts.
  - A loopback receiver with sh_invalid threshold 6 drops lock.
- Start edge with count=0, and a second edge while busy:
  - No headers are corrupted and inj_cnt is unchanged.
  - The word stream matches the reference model.

Source files
------------

// File: rtl/pcs_tx_pkg.sv
// Shared constants and helpers for the 64b/66b transmit path.
// Sync-header codes, gearbox geometry and the header-corruption helper.
package pcs_tx_pkg;

    localparam int NB_DATA_CODED  = 66;
    localparam int NB_DATA_OUT    = 64;
    localparam int NB_SEQ         = 6;
    localparam int MAX_INVALID_SH = 6;
    localparam int NB_INVALID_CNT = $clog2(MAX_INVALID_SH) + 1;
    localparam int GEARBOX_RATIO  = 32;

    localparam logic [1:0] SH_DATA    = 2'b01;
    localparam logic [1:0] SH_CTRL    = 2'b10;
    localparam logic [1:0] SH_INVALID = 2'b11;

    localparam logic [NB_SEQ-1:0]         SEQ_FLUSH = 6'd32;
    localparam logic [NB_INVALID_CNT-1:0] INJ_ZERO  = {NB_INVALID_CNT{1'b0}};
    localparam logic [NB_INVALID_CNT-1:0] INJ_ONE   = {{(NB_INVALID_CNT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        PK_IDLE   = 2'd0,
        PK_ACCEPT = 2'd1,
        PK_FLUSH  = 2'd2
    } pack_op_e;

    // Replace the sync header with the invalid code, leaving the payload intact.
    function automatic logic [NB_DATA_CODED-1:0] force_invalid_sh(input logic [NB_DATA_CODED-1:0] blk);
        return {SH_INVALID, blk[NB_DATA_CODED-3:0]};
    endfunction

endpackage

// File: rtl/sh_error_injector.sv
// Sync-header error injector: a rising edge on the start level arms a burst
// of consecutive accepted blocks whose header is forced to the invalid code.
module sh_error_injector
    import pcs_tx_pkg::*;
(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_accept,
    input  logic                      i_rf_inject_start,
    input  logic [NB_INVALID_CNT-1:0] i_rf_inject_count,
    input  logic [NB_DATA_CODED-1:0]  i_data,
    output logic [NB_DATA_CODED-1:0]  o_data,
    output logic                      o_inject_busy
);

    logic                      start_d_r;
    logic [NB_INVALID_CNT-1:0] inj_cnt_r;
    logic                      start_rise_s;
    logic                      busy_s;

    // Edge detect, busy flag and header mux in front of the packer.
    always_comb begin
        start_rise_s = i_rf_inject_start && !start_d_r;
        busy_s       = (inj_cnt_r != INJ_ZERO);
        if (busy_s) begin
            o_data = force_invalid_sh(i_data);
        end else begin
            o_data = i_data;
        end
    end

    assign o_inject_busy = busy_s;

    // Arm on a clean edge while idle; count down only on accepted blocks.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            start_d_r <= 1'b0;
            inj_cnt_r <= INJ_ZERO;
        end else if (i_enable) begin
            start_d_r <= i_rf_inject_start;
            if (start_rise_s && !busy_s && (i_rf_inject_count != INJ_ZERO)) begin
                inj_cnt_r <= i_rf_inject_count;
            end else if (i_accept && busy_s) begin
                inj_cnt_r <= inj_cnt_r - INJ_ONE;
            end else begin
                inj_cnt_r <= inj_cnt_r;
            end
        end else begin
            start_d_r <= start_d_r;
            inj_cnt_r <= inj_cnt_r;
        end
    end

endmodule

// File: rtl/tx_gearbox_66b64b.sv
// 66b->64b transmit gearbox: 32 blocks in, 33 words out, one flush cycle per
// frame during which the source is back-pressured.
module tx_gearbox_66b64b
    import pcs_tx_pkg::*;
(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_valid,
    input  logic [NB_DATA_CODED-1:0]  i_data,
    output logic                      o_ready,
    input  logic                      i_rf_inject_start,
    input  logic [NB_INVALID_CNT-1:0] i_rf_inject_count,
    output logic                      o_inject_busy,
    output logic [NB_DATA_OUT-1:0]    o_data,
    output logic                      o_valid
);

    logic [NB_DATA_CODED-1:0]             blk_s;
    logic                                 accept_s;
    pack_op_e                             op_s;
    logic [NB_SEQ-1:0]                    seq_r;
    logic [NB_DATA_OUT-1:0]               res_r;
    logic [NB_DATA_OUT+NB_DATA_CODED-1:0] cat_s;
    logic [NB_SEQ:0]                      shamt_s;
    logic [NB_DATA_OUT-1:0]               word_s;
    logic [NB_DATA_OUT-1:0]               res_mask_s;
    logic [NB_DATA_OUT-1:0]               res_next_s;

    assign o_ready  = i_reset && i_enable && (seq_r != SEQ_FLUSH);
    assign accept_s = (op_s == PK_ACCEPT);

    sh_error_injector u_sh_error_injector (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .i_accept          (accept_s),
        .i_rf_inject_start (i_rf_inject_start),
        .i_rf_inject_count (i_rf_inject_count),
        .i_data            (i_data),
        .o_data            (blk_s),
        .o_inject_busy     (o_inject_busy)
    );

    // Cycle decode and packing datapath; residual bits only occupy res[F-1:0].
    always_comb begin
        if (!i_reset || !i_enable) begin
            op_s = PK_IDLE;
        end else if (seq_r == SEQ_FLUSH) begin
            op_s = PK_FLUSH;
        end else if (i_valid) begin
            op_s = PK_ACCEPT;
        end else begin
            op_s = PK_IDLE;
        end
        // Bits above F in res are don't-care: the shift selects cat[F+65:F+2].
        shamt_s    = {seq_r, 1'b0} + 7'd2;
        cat_s      = {res_r, blk_s};
        word_s     = NB_DATA_OUT'(cat_s >> shamt_s);
        res_mask_s = (64'd1 << shamt_s) - 64'd1;
        res_next_s = blk_s[NB_DATA_OUT-1:0] & res_mask_s;
    end

    // Registered word output, residual and sequence counter.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            seq_r   <= 6'd0;
            res_r   <= 64'd0;
            o_data  <= 64'd0;
            o_valid <= 1'b0;
        end else begin
            case (op_s)
                PK_ACCEPT: begin
                    o_data  <= word_s;
                    res_r   <= res_next_s;
                    seq_r   <= seq_r + 6'd1;
                    o_valid <= 1'b1;
                end
                PK_FLUSH: begin
                    o_data  <= res_r;
                    seq_r   <= 6'd0;
                    o_valid <= 1'b1;
                end
                default: begin
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_gearbox_66b64b.sv
// Scoreboard bench: a bit-queue reference model predicts the word stream,
// ready and busy; a separate monitor pops expected words on every o_valid.
module tb_tx_gearbox_66b64b;
    import pcs_tx_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_valid = 1'b0;
    logic [65:0] i_data = 66'd0;
    logic        i_rf_inject_start = 1'b0;
    logic [NB_INVALID_CNT-1:0] i_rf_inject_count = '0;
    logic        o_ready;
    logic        o_inject_busy;
    logic [63:0] o_data;
    logic        o_valid;

    tx_gearbox_66b64b dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .i_valid           (i_valid),
        .i_data            (i_data),
        .o_ready           (o_ready),
        .i_rf_inject_start (i_rf_inject_start),
        .i_rf_inject_count (i_rf_inject_count),
        .o_inject_busy     (o_inject_busy),
        .o_data            (o_data),
        .o_valid           (o_valid)
    );

    initial forever #5 i_clock = ~i_clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    bit          bits_q[$];
    bit          rx_q[$];
    int          m_acc = 0;
    int          m_inj = 0;
    bit          m_prev_start = 1'b0;
    bit          exp_valid = 1'b0;
    bit          prev_rst = 1'b1;
    int          rx_run = 0;
    int          rx_max_run = 0;
    bit          first_pending = 1'b0;
    logic [63:0] first_word = 64'd0;
    bit          st_lvl = 1'b0;

    function automatic void check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [65:0] rblk(input bit data_only);
        logic [1:0] h;
        h = (data_only || $urandom_range(0, 1) == 0) ? SH_DATA : SH_CTRL;
        return {h, $urandom(), $urandom()};
    endfunction

    // One clock of stimulus plus per-cycle checks and reference-model update.
    task automatic cycle(input bit rst, input bit en, input bit vld, input logic [65:0] d,
                         input bit st, input logic [NB_INVALID_CNT-1:0] cnt);
        logic [65:0] blk;
        logic [63:0] w;
        bit acc;
        bit flush;
        bit busy;
        @(negedge i_clock);
        i_reset = rst; i_enable = en; i_valid = vld; i_data = d;
        i_rf_inject_start = st; i_rf_inject_count = cnt;
        #1;
        check("ready", o_ready, rst && en && (m_acc != 32));
        check("busy", o_inject_busy, m_inj != 0);
        check("valid", o_valid, exp_valid);
        if (prev_rst) check("reset_data", o_data, 66'd0);
        acc   = vld && rst && en && (m_acc != 32);
        flush = rst && en && (m_acc == 32);
        if (!rst) begin
            check("reset_pending", exp_q.size(), 66'd0);
            exp_q.delete(); bits_q.delete(); rx_q.delete();
            m_acc = 0; m_inj = 0; m_prev_start = 1'b0; rx_run = 0;
        end else if (en) begin
            busy = (m_inj != 0);
            blk  = d;
            if (acc) begin
                if (busy) begin
                    blk[65:64] = 2'b11;
                    m_inj--;
                end
                for (int i = 65; i >= 0; i--) bits_q.push_back(blk[i]);
                while (bits_q.size() >= 64) begin
                    for (int i = 63; i >= 0; i--) w[i] = bits_q.pop_front();
                    exp_q.push_back(w);
                end
            end
            if (st && !m_prev_start && !busy && cnt != 0) m_inj = cnt;
            m_prev_start = st;
            if (m_acc == 32) m_acc = 0;
            else if (acc) m_acc++;
        end
        exp_valid = acc || flush;
        prev_rst  = !rst;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) cycle(1, 1, 0, 66'd0, 0, 0);
        cycle(1, 1, 0, 66'd0, 0, 0);
        check("drain_empty", exp_q.size(), 66'd0);
    endtask

    // Monitor: pop and compare on every output word; also a loopback receiver.
    initial begin
        logic [63:0] e;
        logic [1:0]  h;
        bit          dump;
        forever begin
            @(posedge i_clock);
            #1;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL word: got %h expected no word", o_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word", o_data, e);
                end
                if (first_pending) begin
                    first_word = o_data;
                    first_pending = 1'b0;
                end
                for (int i = 63; i >= 0; i--) rx_q.push_back(o_data[i]);
                while (rx_q.size() >= 66) begin
                    h[1] = rx_q.pop_front();
                    h[0] = rx_q.pop_front();
                    for (int i = 0; i < 64; i++) dump = rx_q.pop_front();
                    if (h == SH_INVALID || h == 2'b00) rx_run++;
                    else rx_run = 0;
                    if (rx_run > rx_max_run) rx_max_run = rx_run;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int gap;
        bit en;
        repeat (3) cycle(0, 1, 1, rblk(0), 0, 0);

        // Gapless frame starting with the known block.
        first_pending = 1'b1;
        cycle(1, 1, 1, 66'h1_0123456789ABCDEF, 0, 0);
        for (int i = 0; i < 31; i++) cycle(1, 1, 1, rblk(0), 0, 0);
        cycle(1, 1, 1, rblk(0), 0, 0);
        drain();
        check("first_word", first_word, 64'h4048D159E26AF37B);

        // Random gaps, plus a deliberate gap exactly at the flush slot.
        for (int k = 0; k < 100; k++) begin
            gap = $urandom_range(0, 5);
            repeat (gap) cycle(1, 1, 0, rblk(0), 0, 0);
            cycle(1, 1, 1, rblk(0), 0, 0);
        end
        guard = 0;
        while (m_acc != 32 && guard < 80) begin
            cycle(1, 1, 1, rblk(0), 0, 0);
            guard++;
        end
        cycle(1, 1, 0, rblk(0), 0, 0);
        drain();

        // Reset in mid-frame at seq 17.
        guard = 0;
        while (m_acc != 17 && guard < 80) begin
            cycle(1, 1, 1, rblk(0), 0, 0);
            guard++;
        end
        repeat (2) cycle(0, 1, 1, rblk(0), 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, 1, 1, rblk(0), 0, 0);
        drain();

        // Injection burst of 6 on data blocks; loopback must see a run of 6.
        rx_max_run = 0;
        for (int i = 0; i < 20; i++) cycle(1, 1, 1, rblk(1), 1, 4'd6);
        drain();
        check("rx_unlock_run", rx_max_run, 66'd6);

        // Count of zero, then a second edge while busy.
        cycle(1, 1, 0, rblk(0), 1, 4'd0);
        cycle(1, 1, 0, rblk(0), 0, 4'd0);
        cycle(1, 1, 0, rblk(0), 1, 4'd3);
        cycle(1, 1, 0, rblk(0), 0, 4'd3);
        cycle(1, 1, 0, rblk(0), 1, 4'd5);
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, rblk(0), 1, 4'd5);
        drain();

        // Random mix of enables, valids and injection edges.
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) st_lvl = !st_lvl;
            cycle(1, en, ($urandom_range(0, 3) != 0), rblk(0), st_lvl,
                  NB_INVALID_CNT'($urandom_range(0, MAX_INVALID_SH)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
